// File: rtl/fifo_wr_front.sv
// RX async FIFO write front end: 2-entry skid buffer, paced pushes, rd-pointer sync, drop counter.
// Latency rx_valid_wr -> wr_inc_wr is 2 cycles; while full_wr is high the buffer fills, then bytes are dropped.
module fifo_wr_front #(
    parameter int DATA_WIDTH  = 8,
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_ON_ERR = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  wr_clk_wr,
    input  logic                  wr_rst_wr,
    input  logic [DATA_WIDTH-1:0] rx_data_wr,
    input  logic                  rx_valid_wr,
    input  logic                  rx_err_wr,
    input  logic [PTR_WIDTH-1:0]  rd_ptr_gray,
    output logic [PTR_WIDTH-1:0]  wq2_rptr_wr,
    input  logic                  full_wr,
    output logic                  wr_inc_wr,
    output logic [DATA_WIDTH-1:0] wr_data_wr,
    output logic [1:0]            buf_level_wr,
    output logic [CNT_WIDTH-1:0]  ovf_cnt_wr,
    output logic                  ovf_flag_wr,
    input  logic                  ovf_clr_wr
);

    typedef enum logic [1:0] {ST_IDLE, ST_PUSH, ST_GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 ERR_DROP_EN = (DROP_ON_ERR != 0);

    state_t                state_q, state_d;
    logic                  wr_inc_q, wr_inc_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [1:0]            level_q, level_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  flag_q, flag_d;
    logic [PTR_WIDTH-1:0]  sync_q [SYNC_STAGES];

    logic pop, cand, accept, drop, wr_sel;

    // Plain flop chain: no logic between stages so each bit resolves independently.
    always_ff @(posedge wr_clk_wr or negedge wr_rst_wr) begin
        if (!wr_rst_wr) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // The PUSH/GAP dwell hides fifo_wr's registered pointer latency, so full_wr is trusted only in IDLE.
    always_comb begin
        state_d   = state_q;
        wr_inc_d  = 1'b0;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != 2'd0 && !full_wr) begin
                    wr_inc_d  = 1'b1;
                    wr_data_d = buf_q[0];
                    pop       = 1'b1;
                    state_d   = ST_PUSH;
                end
            end
            ST_PUSH: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cand   = rx_valid_wr && !(ERR_DROP_EN && rx_err_wr);
    assign accept = cand && (level_q != 2'd2 || pop);
    assign drop   = cand && !accept;
    // Tail slot after any same-edge pop has shifted the head out.
    assign wr_sel = pop ? (level_q == 2'd2) : (level_q == 2'd1);

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        level_d  = level_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            level_d  = level_q - 2'd1;
        end
        if (accept) begin
            if (wr_sel) buf_d[1] = rx_data_wr;
            else        buf_d[0] = rx_data_wr;
            level_d = pop ? level_q : level_q + 2'd1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (ovf_clr_wr) begin
            cnt_d  = drop ? CNT_ONE : '0;
            flag_d = drop;
        end else if (drop) begin
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk_wr or negedge wr_rst_wr) begin
        if (!wr_rst_wr) begin
            state_q   <= ST_IDLE;
            wr_inc_q  <= 1'b0;
            wr_data_q <= '0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            level_q   <= 2'd0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_inc_q  <= wr_inc_d;
            wr_data_q <= wr_data_d;
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
        end
    end

    assign wq2_rptr_wr  = sync_q[SYNC_STAGES-1];
    assign wr_inc_wr    = wr_inc_q;
    assign wr_data_wr   = wr_data_q;
    assign buf_level_wr = level_q;
    assign ovf_cnt_wr   = cnt_q;
    assign ovf_flag_wr  = flag_q;

endmodule

// File: tb/tb_fifo_wr_front.sv
// Directed bench for fifo_wr_front: push pacing, skid buffer, overflow count, pointer sync, async reset.
module tb_fifo_wr_front;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;
    logic [3:0] rd_ptr;
    logic [3:0] wq2;
    logic       full;
    logic       inc;
    logic [7:0] wdata;
    logic [1:0] level;
    logic [7:0] cnt;
    logic       flag;
    logic       clr;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_front dut (
        .wr_clk_wr    (clk),
        .wr_rst_wr    (rst_n),
        .rx_data_wr   (rx_data),
        .rx_valid_wr  (rx_valid),
        .rx_err_wr    (rx_err),
        .rd_ptr_gray  (rd_ptr),
        .wq2_rptr_wr  (wq2),
        .full_wr      (full),
        .wr_inc_wr    (inc),
        .wr_data_wr   (wdata),
        .buf_level_wr (level),
        .ovf_cnt_wr   (cnt),
        .ovf_flag_wr  (flag),
        .ovf_clr_wr   (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
        rd_ptr = '0; full = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inc",   inc === 1'b0);
        chk("rst_data",  wdata === 8'h00);
        chk("rst_level", level === 2'd0);
        chk("rst_cnt",   cnt === 8'd0);
        chk("rst_flag",  flag === 1'b0);
        chk("rst_wq2",   wq2 === 4'b0000);
        rst_n = 1'b1;
        tick();

        // Single byte: push appears two cycles after the strobe.
        strobe(8'hA5);
        chk("a5_c1_level", level === 2'd1);
        chk("a5_c1_inc",   inc === 1'b0);
        tick();
        chk("a5_c2_inc",   inc === 1'b1);
        chk("a5_c2_data",  wdata === 8'hA5);
        chk("a5_c2_level", level === 2'd0);
        tick();
        chk("a5_c3_inc",   inc === 1'b0);
        chk("a5_c3_hold",  wdata === 8'hA5);
        repeat (3) tick();

        // Back-to-back bytes: pushes in cycles 2, 5, 8.
        strobe(8'h11);
        strobe(8'h22);
        chk("b2b_c2_inc",  inc === 1'b1);
        chk("b2b_c2_data", wdata === 8'h11);
        strobe(8'h33);
        chk("b2b_c3_level", level === 2'd2);
        for (int c = 3; c <= 8; c++) begin
            if (c > 3) tick();
            chk("b2b_inc", inc === ((c == 5) || (c == 8)));
            if (c == 5) chk("b2b_c5_data", wdata === 8'h22);
            if (c == 8) chk("b2b_c8_data", wdata === 8'h33);
        end
        chk("b2b_level", level === 2'd0);
        chk("b2b_cnt",   cnt === 8'd0);
        repeat (3) tick();

        // Full: buffer holds two, third dropped.
        full = 1'b1;
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        chk("full_level", level === 2'd2);
        chk("full_cnt",   cnt === 8'd1);
        chk("full_flag",  flag === 1'b1);
        chk("full_inc",   inc === 1'b0);
        full = 1'b0;
        tick();
        chk("drain_inc0",  inc === 1'b1);
        chk("drain_data0", wdata === 8'h01);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("drain_inc", inc === (k == 3));
        end
        chk("drain_data1", wdata === 8'h02);
        chk("drain_level", level === 2'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt",  cnt === 8'd0);
        chk("clr_flag", flag === 1'b0);

        // Errored byte discarded, not counted.
        rx_err = 1'b1;
        strobe(8'h55);
        rx_err = 1'b0;
        chk("err_level", level === 2'd0);
        repeat (2) tick();
        chk("err_inc",  inc === 1'b0);
        chk("err_cnt",  cnt === 8'd0);
        chk("err_flag", flag === 1'b0);

        // Pointer synchroniser: two edges.
        rd_ptr = 4'b0001;
        tick();
        chk("sync_edge1", wq2 === 4'b0000);
        tick();
        chk("sync_edge2", wq2 === 4'b0001);

        // Clear coinciding with a drop, then saturation.
        full = 1'b1;
        for (int k = 0; k < 4; k++) strobe(8'(8'h40 + k));
        chk("pre_clr_cnt", cnt === 8'd2);
        rx_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_drop_cnt",  cnt === 8'd1);
        chk("clr_drop_flag", flag === 1'b1);
        repeat (253) tick();
        chk("sat_254", cnt === 8'd254);
        tick();
        chk("sat_255", cnt === 8'd255);
        repeat (46) tick();
        rx_valid = 1'b0;
        chk("sat_hold",  cnt === 8'd255);
        chk("sat_level", level === 2'd2);

        // Reset asserted while a push is on the wire.
        full = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (inc === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("push_seen", got === 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inc",   inc === 1'b0);
        chk("mid_rst_data",  wdata === 8'h00);
        chk("mid_rst_cnt",   cnt === 8'd0);
        chk("mid_rst_level", level === 2'd0);
        chk("mid_rst_flag",  flag === 1'b0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
